sequential_prefix_sub: RTL and testbench

//  Multi-cycle fixed-point subtractor: c = a - b - bi, computed W bits per clock with a registered borrow chain.

---
 rtl/fixed_point_arith_pkg.sv | 20 ++
 rtl/prefix_sub_slice.sv | 45 ++++
 rtl/sequential_prefix_sub.sv | 117 +++++++++++
 tb/tb_sequential_prefix_sub.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fixed_point_arith_pkg.sv
// Shared types and elaboration helpers for the fixed-point arithmetic units.
package fixed_point_arith_pkg;

   typedef enum logic [1:0] {SUB_IDLE, SUB_BUSY, SUB_DONE} sub_state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int k = 0; k < 32; k++) begin
         if ((1 << r) < v) r++;
      end
      return r;
   endfunction

   // Register index width; never zero even for a single-slice build.
   function automatic int clog2_min1(input int v);
      return (clog2(v) < 1) ? 1 : clog2(v);
   endfunction

endpackage

// File: rtl/prefix_sub_slice.sv
// Combinational W-bit Kogge-Stone adder slice; subtract is formed by the caller feeding ~b and ~borrow.
module prefix_sub_slice
   import fixed_point_arith_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   localparam int L = clog2(W);

   logic [L:0][W-1:0] gg;
   logic [L:0][W-1:0] pp;
   logic [W:0]        cy;

   assign gg[0] = x & y;
   assign pp[0] = x ^ y;

   for (genvar d = 1; d <= L; d++) begin : g_lvl
      localparam int D = 1 << (d - 1);
      for (genvar i = 0; i < W; i++) begin : g_bit
         if (i >= D) begin : g_merge
            assign gg[d][i] = gg[d-1][i] | (pp[d-1][i] & gg[d-1][i-D]);
            assign pp[d][i] = pp[d-1][i] & pp[d-1][i-D];
         end else begin : g_pass
            assign gg[d][i] = gg[d-1][i];
            assign pp[d][i] = pp[d-1][i];
         end
      end
   end

   // Group terms span bit 0..i, so cin folds in once at the end.
   assign cy[0] = cin;
   for (genvar i = 0; i < W; i++) begin : g_cy
      assign cy[i+1] = gg[L][i] | (pp[L][i] & cin);
   end

   assign s    = pp[0] ^ cy[W-1:0];
   assign cout = cy[W];

endmodule

// File: rtl/sequential_prefix_sub.sv
// Multi-cycle c = a - b - bi, W bits per clock; ov port only with PREFIX_SUB_OVERFLOW_EN.
// Latency N/W clocks from accept to out_valid; one op per N/W+2 clocks.
// in_ready only in IDLE; result held in DONE until out_ready.
module sequential_prefix_sub
   import fixed_point_arith_pkg::*;
#(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bi,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] c,
   output logic         bo
`ifdef PREFIX_SUB_OVERFLOW_EN
  ,output logic         ov
`endif
);

   localparam int S  = N / W;
   localparam int IW = clog2_min1(S);

   if (N % W != 0) begin : g_bad_width
      $error("sequential_prefix_sub: N must be a multiple of W");
   end

   sub_state_t    state, state_nx;
   logic [N-1:0]  a_r;
   logic [N-1:0]  nb_r;
   logic          carry;
   logic [IW-1:0] idx;
   logic [W-1:0]  s;
   logic          cout;
   logic          last;

   assign last = (idx == IW'(S - 1));

   prefix_sub_slice #(.W(W)) u_slice (
      .x    (a_r[idx*W +: W]),
      .y    (nb_r[idx*W +: W]),
      .cin  (carry),
      .s    (s),
      .cout (cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SUB_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         SUB_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = SUB_BUSY;
         end
         SUB_BUSY: begin
            if (last) state_nx = SUB_DONE;
         end
         SUB_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = SUB_IDLE;
         end
         default: state_nx = SUB_IDLE;
      endcase
   end

   // Borrow chain is carried as an inverted carry: a + ~b + ~bi.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r   <= '0;
         nb_r  <= '0;
         carry <= 1'b0;
         idx   <= '0;
         c     <= '0;
         bo    <= 1'b0;
`ifdef PREFIX_SUB_OVERFLOW_EN
         ov    <= 1'b0;
`endif
      end else begin
         case (state)
            SUB_IDLE: begin
               if (in_valid) begin
                  a_r   <= a;
                  nb_r  <= ~b;
                  carry <= ~bi;
                  idx   <= '0;
               end
            end
            SUB_BUSY: begin
               c[idx*W +: W] <= s;
               carry         <= cout;
               idx           <= idx + 1'b1;
               if (last) begin
                  idx <= '0;
                  bo  <= ~cout;
`ifdef PREFIX_SUB_OVERFLOW_EN
                  // nb_r holds ~b, so equal MSBs mean a and b differ in sign.
                  ov  <= (a_r[N-1] == nb_r[N-1]) && (s[W-1] != a_r[N-1]);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sequential_prefix_sub.sv
// Directed and small randomized checks of sequential_prefix_sub at N=32, W=8.
module tb_sequential_prefix_sub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        bi = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] c;
   logic        bo;
`ifdef PREFIX_SUB_OVERFLOW_EN
   logic        ov;
`endif

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   sequential_prefix_sub #(.N(32), .W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bi        (bi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .bo        (bo)
`ifdef PREFIX_SUB_OVERFLOW_EN
     ,.ov        (ov)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one op, check latency and result, hold out_ready low for gap cycles.
   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tbi, input logic [31:0] ec, input logic ebo,
                         input logic eov, input int gap);
      int lat;
      @(negedge clk);
      chk({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
      a = ta; b = tb_; bi = tbi; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; bi = 1'($urandom);
      chk({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 50) begin
         in_valid = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "/latency"}, 32'(lat), 32'd4);
      chk({tag, "/c"}, c, ec);
      chk({tag, "/bo"}, 32'(bo), 32'(ebo));
`ifdef PREFIX_SUB_OVERFLOW_EN
      chk({tag, "/ov"}, 32'(ov), 32'(eov));
`else
      if (eov === 1'bx) chk({tag, "/eov_known"}, 32'(eov), 32'd0);
`endif
      for (int i = 0; i < gap; i++) begin
         in_valid = 1'($urandom);
         a = $urandom; b = $urandom;
         @(negedge clk);
         chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "/hold_c"}, c, ec);
         chk({tag, "/hold_bo"}, 32'(bo), 32'(ebo));
         chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "/drained"}, 32'(out_valid), 32'd0);
      chk({tag, "/in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [32:0] d;
      logic [31:0] ra, rb;
      logic        rbi, rov;

      #2;
      chk("rst/in_ready", 32'(in_ready), 32'd1);
      chk("rst/out_valid", 32'(out_valid), 32'd0);
      chk("rst/c", c, 32'd0);
      chk("rst/bo", 32'(bo), 32'd0);
`ifdef PREFIX_SUB_OVERFLOW_EN
      chk("rst/ov", 32'(ov), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      run_op("5-3",      32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0, 0);
      run_op("0-1",      32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
      run_op("10-0f-1",  32'h10,         32'h0F,         1'b1, 32'h0000_0000, 1'b0, 1'b0, 0);
      run_op("0-0-1",    32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
      run_op("min-1",    32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
      run_op("1-2",      32'd1,          32'd2,          1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
      run_op("bp",       32'h1234_5678,  32'h0234_5679,  1'b0, 32'h0FFF_FFFF, 1'b0, 1'b0, 10);

      // Reset asserted mid-compute with slices 0 and 1 already written.
      @(negedge clk);
      a = 32'hFFFF_FFFF; b = 32'd0; bi = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("arst/out_valid", 32'(out_valid), 32'd0);
      chk("arst/in_ready", 32'(in_ready), 32'd1);
      chk("arst/c", c, 32'd0);
      chk("arst/bo", 32'(bo), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 0);

      for (int n = 0; n < 200; n++) begin
         ra = $urandom; rb = $urandom; rbi = 1'($urandom);
         if (n % 8 == 0) rb = ra;
         d = {1'b0, ra} - {1'b0, rb} - 33'(rbi);
         rov = (ra[31] != rb[31]) && (d[31] != ra[31]);
         run_op("rand", ra, rb, rbi, d[31:0], d[32], rov, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
